// File: rtl/nes_clk_pkg.sv
// Shared types and default timing for the NES clock/reset sequencing logic.
// State encodings are also exported on state_dbg, so their values are fixed.
package nes_clk_pkg;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_STABLE = 3'd1,
    ST_REL    = 3'd2,
    ST_RUN    = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_STAGE_GAP      = 16;
  localparam int DEF_MIN_RST_CYCLES = 32;

  localparam logic [7:0] LOST_MAX = 8'hFF;

  // Sized to hold the longest interval any state has to count.
  function automatic int seq_cnt_width(input int stable, input int gap, input int min_rst);
    int m;
    m = stable;
    if (2 * gap > m) m = 2 * gap;
    if (min_rst > m) m = min_rst;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop single-bit synchroniser with asynchronous active-low clear.
// Latency STAGES clk edges; no backpressure.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// Qualifies PLL lock and releases memory, PPU, then CPU resets in order.
// Lock loss or a soft reset forces every reset low for a guaranteed width.
module pll_rst_seq
  import nes_clk_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int STAGE_GAP      = DEF_STAGE_GAP,
  parameter int MIN_RST_CYCLES = DEF_MIN_RST_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       sw_rst_req,
  output logic       rst_mem_n,
  output logic       rst_ppu_n,
  output logic       rst_cpu_n,
  output logic       pll_ok,
  output logic [7:0] lost_count,
  output logic [2:0] state_dbg
);

  localparam int CW = seq_cnt_width(STABLE_CYCLES, STAGE_GAP, MIN_RST_CYCLES);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST    = CW'(2 * STAGE_GAP - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(MIN_RST_CYCLES - 1);
  localparam logic [CW-1:0] PPU_AT      = CW'(STAGE_GAP);

  logic          lock_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          loss_evt;

  logic          mem_q, mem_d;
  logic          ppu_q, ppu_d;
  logic          cpu_q, cpu_d;
  logic          ok_q, ok_d;
  logic [7:0]    lost_q, lost_d;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      mem_q   <= 1'b0;
      ppu_q   <= 1'b0;
      cpu_q   <= 1'b0;
      ok_q    <= 1'b0;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      ppu_q   <= ppu_d;
      cpu_q   <= cpu_d;
      ok_q    <= ok_d;
      lost_q  <= lost_d;
    end
  end

  // Counter restarts from zero on every transition; RUN and WAIT leave it idle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    loss_evt = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (lock_s) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        if (!lock_s)                  state_d = ST_WAIT;
        else if (cnt_q == STABLE_LAST) state_d = ST_REL;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      ST_REL: begin
        if (!lock_s) begin
          state_d  = ST_HOLD;
          loss_evt = 1'b1;
        end else if (sw_rst_req) begin
          state_d = ST_HOLD;
        end else if (cnt_q == REL_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d  = ST_HOLD;
          loss_evt = 1'b1;
        end else if (sw_rst_req) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = ST_WAIT;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_comb begin
    mem_d  = (state_d == ST_REL) || (state_d == ST_RUN);
    ppu_d  = ((state_d == ST_REL) && (cnt_d >= PPU_AT)) || (state_d == ST_RUN);
    cpu_d  = (state_d == ST_RUN);
    ok_d   = (state_d == ST_RUN);
    lost_d = lost_q;
    if (loss_evt && (lost_q != LOST_MAX)) lost_d = lost_q + 8'd1;
  end

  assign rst_mem_n  = mem_q;
  assign rst_ppu_n  = ppu_q;
  assign rst_cpu_n  = cpu_q;
  assign pll_ok     = ok_q;
  assign lost_count = lost_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Randomised and directed stimulus for pll_rst_seq, checked through a scoreboard
// fed by a timeline reference model of the lock-qualify / release / hold rules.
module tb_pll_rst_seq;

  localparam int S  = 2;
  localparam int SC = 8;
  localparam int G  = 4;
  localparam int MR = 6;

  typedef struct packed {
    logic       mem;
    logic       ppu;
    logic       cpu;
    logic       ok;
    logic [7:0] lost;
    logic [2:0] st;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       sw_rst_req;
  logic       rst_mem_n, rst_ppu_n, rst_cpu_n, pll_ok;
  logic [7:0] lost_count;
  logic [2:0] state_dbg;

  pll_rst_seq #(
    .SYNC_STAGES    (S),
    .STABLE_CYCLES  (SC),
    .STAGE_GAP      (G),
    .MIN_RST_CYCLES (MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .sw_rst_req (sw_rst_req),
    .rst_mem_n  (rst_mem_n),
    .rst_ppu_n  (rst_ppu_n),
    .rst_cpu_n  (rst_cpu_n),
    .pll_ok     (pll_ok),
    .lost_count (lost_count),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp;
  int   n_bad;
  obs_t exp_q[$];

  // Reference model: lock history, release edge and hold deadline in edge numbers.
  bit hist[$];
  int cyc;
  bit m_rel;
  bit m_hold;
  int tm;
  int hold_until;
  int run_len;
  int lost;

  function automatic obs_t get_obs();
    obs_t o;
    o = {rst_mem_n, rst_ppu_n, rst_cpu_n, pll_ok, lost_count, state_dbg};
    return o;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back(1'b0);
    cyc = 0; m_rel = 0; m_hold = 0; tm = 0; hold_until = 0; run_len = 0; lost = 0;
  endtask

  function automatic obs_t model_step(input bit p, input bit s);
    obs_t o;
    bit   ls;
    int   d;
    cyc++;
    ls = hist.pop_front();
    hist.push_back(p);
    if (m_hold) begin
      if (cyc == hold_until) begin
        m_hold  = 0;
        run_len = 0;
      end
    end else if (m_rel) begin
      if (cyc > tm && (!ls || s)) begin
        if (!ls) lost = (lost < 255) ? lost + 1 : 255;
        m_rel      = 0;
        m_hold     = 1;
        hold_until = cyc + MR;
      end
    end else begin
      run_len = ls ? run_len + 1 : 0;
      if (run_len == SC + 1) begin
        m_rel   = 1;
        tm      = cyc;
        run_len = 0;
      end
    end
    o = '0;
    o.lost = 8'(lost);
    if (m_hold) begin
      o.st = 3'd4;
    end else if (m_rel) begin
      d     = cyc - tm;
      o.mem = 1'b1;
      o.ppu = (d >= G);
      o.cpu = (d >= 2 * G);
      o.ok  = (d >= 2 * G);
      o.st  = (d >= 2 * G) ? 3'd3 : 3'd2;
    end else begin
      o.st = (run_len > 0) ? 3'd1 : 3'd0;
    end
    return o;
  endfunction

  task automatic drive(input bit p, input bit s, input bit r);
    @(negedge clk);
    rst_n      = r;
    pll_lock   = p;
    sw_rst_req = s;
    if (!r) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(model_step(p, s));
    end
  endtask

  task automatic drive_n(input bit p, input int n);
    for (int i = 0; i < n; i++) drive(p, 1'b0, 1'b1);
  endtask

  // Monitor: every edge with a pending expectation is compared.
  initial begin
    obs_t got, want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = get_obs();
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL outputs@t=%0t got mem=%b ppu=%b cpu=%b ok=%b lost=%0d st=%0d expected mem=%b ppu=%b cpu=%b ok=%b lost=%0d st=%0d",
                   $time, got.mem, got.ppu, got.cpu, got.ok, got.lost, got.st,
                   want.mem, want.ppu, want.cpu, want.ok, want.lost, want.st);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    bit   lvl;
    int   guard;
    obs_t got;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; pll_lock = 1'b0; sw_rst_req = 1'b0;
    model_reset();

    // Board reset, then normal power-up into RUN.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
    drive_n(1'b0, 4);
    drive_n(1'b1, 35);

    // Lock loss in RUN, then unstable relock (5 high, 3 low) before a clean one.
    drive_n(1'b0, 12);
    drive_n(1'b1, 5);
    drive_n(1'b0, 3);
    drive_n(1'b1, 30);

    // Soft reset in RUN leaves lost_count alone.
    drive(1'b1, 1'b1, 1'b1);
    drive_n(1'b1, 30);

    // Lock loss and soft request seen on the same edge count once.
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive_n(1'b0, 10);
    drive_n(1'b1, 30);

    // Random lock flicker and soft requests.
    lvl = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) lvl = ~lvl;
      drive(lvl, ($urandom_range(29) == 0), 1'b1);
    end

    // Repeated losses push the counter into saturation.
    for (int i = 0; i < 270; i++) begin
      drive_n(1'b1, 12);
      drive_n(1'b0, 8);
    end
    drive_n(1'b1, 30);

    // Async reset arriving mid-REL must clear every output before any edge.
    drive_n(1'b0, 12);
    guard = 0;
    while (!(m_rel && (cyc - tm) == 1) && guard < 60) begin
      drive(1'b1, 1'b0, 1'b1);
      guard++;
    end
    n_cmp++;
    if (guard >= 60) begin
      n_bad++;
      $display("FAIL reach_rel: REL not reached within %0d cycles", guard);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    got = get_obs();
    n_cmp++;
    if (got !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL async_reset: got %h expected %h", got, obs_t'(0));
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
    drive_n(1'b1, 30);

    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Consumes the asynchronous lock output of the rPLL and produces staged, glitch-free resets for the NES subsystems. Runs on the divided PLL clock (CLKOUTD, 21.6 MHz).
- Qualifies lock for a programmable time, then releases resets in order: memory/SDRAM, then PPU, then CPU.
- On lock loss or a soft-reset request, re-asserts all resets for a guaranteed minimum width. Counts lock-loss events for debug/LED display.

Parameters:
SYNC_STAGES, 2, flops in the pll_lock synchroniser (min 2)
STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release (min 2)
STAGE_GAP, 16, cycles between successive reset-stage releases (min 1)
MIN_RST_CYCLES, 32, cycles all resets stay asserted after a loss or soft reset (min 1)

Ports:
clk  in  1  CLKOUTD-domain clock
rst_n  in  1  asynchronous active-low reset (board reset)
pll_lock  in  1  raw PLL LOCK, asynchronous to clk
sw_rst_req  in  1  synchronous single-cycle soft-reset request
rst_mem_n  out  1  active-low reset, memory controller (released first)
rst_ppu_n  out  1  active-low reset, PPU (released second)
rst_cpu_n  out  1  active-low reset, CPU/APU (released last)
pll_ok  out  1  high while in RUN
lost_count  out  8  saturating count of lock losses after release
state_dbg  out  3  current state encoding

Behaviour:
- Reset (rst_n=0, asynchronous): state=WAIT, synchroniser flops=0, counter=0, lost_count=0, all rst_*_n=0, pll_ok=0. All outputs are registered.
- lock_s = last synchroniser stage. t0 = first edge that samples pll_lock=1; lock_s is 1 after edge t0+SYNC_STAGES-1.
- One counter, width $clog2(max(STABLE_CYCLES, 2*STAGE_GAP, MIN_RST_CYCLES))+1. Cleared on every state change.
- States (WAIT=0, STABLE=1, REL=2, RUN=3, HOLD=4):
- WAIT: resets asserted. lock_s=1 -> STABLE.
- STABLE: counter increments each cycle.
  - lock_s=0 -> WAIT. Not counted as a loss.
  - After STABLE_CYCLES cycles in STABLE -> REL.
  - sw_rst_req ignored.
- REL: rst_mem_n goes high on the entry edge, so rst_mem_n rises at t0+SYNC_STAGES+STABLE_CYCLES (call this edge Tm).
  - rst_ppu_n rises at Tm+STAGE_GAP.
  - At Tm+2*STAGE_GAP: rst_cpu_n=1, pll_ok=1, state -> RUN.
- RUN: all resets high. Stays in RUN until lock loss or sw_rst_req.
- Lock loss in REL or RUN (lock_s=0) -> HOLD on that edge. All rst_*_n=0 and pll_ok=0 on the same edge. lost_count increments, saturating at 255.
- sw_rst_req=1 in REL or RUN -> HOLD. Same output behaviour, but lost_count is unchanged.
- Simultaneous lock loss and sw_rst_req: treated as lock loss; lost_count increments once.
- HOLD: all resets low for exactly MIN_RST_CYCLES cycles, then -> WAIT, where lock is re-qualified from zero.
  - lock_s changes and sw_rst_req are ignored during HOLD.
  - Loss latency: t1 = first edge sampling pll_lock=0; resets fall at t1+SYNC_STAGES.
- A pll_lock glitch shorter than one clk may or may not propagate. Either outcome is legal; no metastable value may reach the FSM.
- Reset order invariant: rst_cpu_n=1 implies rst_ppu_n=1, and rst_ppu_n=1 implies rst_mem_n=1, every cycle.
- Illegal state encodings recover to WAIT with all resets asserted.

Decomposition:
- Shared package (nes_clk_pkg) holds the state enum/localparams and the default timing constants.
- One natural sub-module: sync_ff, a SYNC_STAGES-deep bit synchroniser with async active-low clear. It is reusable for other CDC bits.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=8, STAGE_GAP=4, MIN_RST_CYCLES=6):
- Normal power-up: rst_n released, pll_lock=1 sampled at edge 5 -> rst_mem_n↑@15, rst_ppu_n↑@19, rst_cpu_n↑ and pll_ok↑@23, lost_count=0.
- Unstable lock: pll_lock high 5 cycles, low 3, then high -> no reset released until 8 consecutive lock_s cycles; lost_count stays 0.
- Lock loss in RUN: pll_lock=0 sampled at edge 100 -> all resets low and pll_ok low @102, state HOLD; WAIT @108; lost_count=1; re-release follows the power-up timing.
- Soft reset in RUN, with sw_rst_req and lock loss together in a later RUN -> first: HOLD for 6 cycles with lost_count unchanged; second: lost_count increments by exactly 1.
- Saturation and async reset: force 260 losses -> lost_count holds 255; assert rst_n mid-REL -> all outputs 0 immediately, before any clock edge.
